// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud divisor helper, data width.
package uart_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  function automatic int unsigned baud_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync_fifo.sv
// Single-clock FIFO (DEPTH x WIDTH register array) with flush; shared by the UART rx and tx paths.
module uart_rx_sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rdata = mem[rd_ptr];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive path: 2-flop rxd synchronizer, 8N1 deserializer FSM and FIFO drained via ctrl PIO.
// Define UART_RX_PARITY_EN for 8E1 framing (even parity checked, bad parity discards the byte).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     rxd,
  input  logic [1:0]               ctrl,
  output logic [DATA_W-1:0]        rx_data,
  output logic                     rx_valid,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overrun,
  output logic                     framing_err
);

  localparam int unsigned BAUD_DIV = baud_div(CLK_HZ, BAUD);
  localparam int unsigned HALF     = BAUD_DIV / 2;
  localparam int unsigned CW       = $clog2(BAUD_DIV);

  logic              rx_meta;
  logic              rxs;
  logic              rxs_q;
  rx_state_t         state;
  logic [CW-1:0]     baud_cnt;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              push_req;
  logic              frame_bad;
  logic              baud_end;
  logic              accept;
  logic              ctrl0_q;
  logic              pop;
  logic              flush;
  logic              fifo_full;
  logic              fifo_empty;

  assign baud_end = (baud_cnt == CW'(BAUD_DIV - 1));
  assign pop      = ctrl[0] & ~ctrl0_q;
  assign flush    = ctrl[1];

`ifdef UART_RX_PARITY_EN
  logic parity_bad;
  assign accept = rxs & ~parity_bad;
`else
  assign accept = rxs;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_q   <= 1'b1;
      ctrl0_q <= 1'b0;
    end else begin
      rx_meta <= rxd;
      rxs     <= rx_meta;
      rxs_q   <= rxs;
      ctrl0_q <= ctrl[0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      push_req   <= 1'b0;
      frame_bad  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad <= 1'b0;
`endif
    end else begin
      push_req  <= 1'b0;
      frame_bad <= 1'b0;
      case (state)
        IDLE: begin
          if (rxs_q && !rxs) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end
        START: begin
          if (baud_cnt == CW'(HALF - 1)) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= rxs ? IDLE : DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shift    <= {rxs, shift[DATA_W-1:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud_cnt   <= '0;
            parity_bad <= ^{shift, rxs};
            state      <= STOP;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
            if (accept) push_req  <= 1'b1;
            else        frame_bad <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Full implies non-empty, so a pop edge always frees the slot for a coincident push
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else if (flush) begin
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      if (push_req && fifo_full && !pop) overrun <= 1'b1;
      if (frame_bad) framing_err <= 1'b1;
    end
  end

  uart_rx_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push_req),
    .wdata   (shift),
    .pop     (pop),
    .flush   (flush),
    .rdata   (rx_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign rx_valid = ~fifo_empty;

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Serial receive path of the UART subsystem: deserializes 8-bit frames from the `rxd` pin into a small FIFO. Software drains the FIFO through the 2-bit DataRead PIO output, so this block is the direct consumer of that PIO's `out_port`. `rx_data` and the status outputs return to the CPU through input PIOs. Everything runs in the single Nios system clock domain; only `rxd` is asynchronous.

## Interface
- `CLK_HZ`, 50000000: system clock frequency in Hz.
- `BAUD`, 115200: line rate. `BAUD_DIV = CLK_HZ/BAUD`, integer-truncated (434 at defaults).
- `DEPTH`, 16: FIFO entries. Must be a power of 2 and at least 2.
- `clk` input 1: system clock. All state updates on its rising edge.
- `reset_n` input 1: asynchronous reset, active low.
- `rxd` input 1: serial line, idle high, asynchronous to `clk`.
- `ctrl` input 2: DataRead PIO `out_port`, same clock domain.
  - `[0]` is the pop request; a rising edge pops one entry.
  - `[1]` is flush, level-sensitive.
- `rx_data` output 8: FIFO head entry.
- `rx_valid` output 1: FIFO not empty.
- `fifo_count` output $clog2(DEPTH)+1: number of occupied entries.
- `overrun` output 1: sticky. Set when a byte is dropped because the FIFO is full.
- `framing_err` output 1: sticky. Set when a stop bit is sampled as 0.

## Operation
- All outputs reset to 0. Receiver state resets to IDLE and the FIFO resets to empty.
- `rxd` passes through a 2-flop synchronizer, reset value 1. All logic uses the synchronized value `rxs`.
- Receiver FSM, with a bit counter (0..7) and a baud counter (0..BAUD_DIV-1):
  - **IDLE**: a 1→0 transition on `rxs` enters START and clears the baud counter.
  - **START**: after BAUD_DIV/2 cycles, sample `rxs`.
    - If 1, it was a glitch: return to IDLE.
    - If 0, enter DATA.
  - **DATA**: sample every BAUD_DIV cycles, LSB first, into the shift register. After the 8th bit, go to PARITY if configured, otherwise STOP.
  - **PARITY**: covered under Configuration.
  - **STOP**: after BAUD_DIV cycles, sample `rxs`.
    - If 1, push the byte.
    - If 0, set `framing_err` and discard the byte.
    - Return to IDLE in both cases.
- Pop: registered `ctrl[0]` edge detect. The pop fires on the cycle where `ctrl[0]`=1 and its previous value is 0. A pop on an empty FIFO is ignored.
- Flush: while `ctrl[1]`=1:
  - the FIFO is held empty;
  - `overrun` and `framing_err` are cleared;
  - pushes are dropped.
  - The receiver FSM keeps running.
- Push while full: the byte is dropped, `overrun` is set, and the contents are unchanged.
- Push and pop in the same cycle:
  - Both are performed and `fifo_count` is unchanged.
  - When full, the pop frees the slot and the push succeeds; `overrun` is not set.
- Pointers are $clog2(DEPTH) bits and wrap naturally. `fifo_count` saturates at DEPTH by construction.

## Timing
- Push latency: the byte is written on the cycle after the stop-bit sample. `rx_valid`, `fifo_count` and `rx_data` update one cycle later (registered).
- Pop latency: `rx_data` shows the next entry, and `fifo_count` decrements, one cycle after the detected edge.
- Software protocol: set `ctrl[0]` at PIO address 4, clear it at address 5. One set/clear pair = one pop.
- Frame acceptance: the stop bit is sampled about 9.5 bit-times after the start edge (10.5 with parity), plus 2 synchronizer cycles.
- Reset mid-frame: the FSM returns immediately to IDLE and the partial byte is lost.
- A new start edge is accepted on the cycle after the FSM returns to IDLE, so back-to-back frames with a single stop bit are received.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - 8E1 framing. The PARITY state samples one extra bit after DATA.
  - On even-parity mismatch the byte is discarded and `framing_err` is set; the STOP state still runs.
- `UART_RX_PARITY_EN` undefined:
  - 8N1 framing. The PARITY state and parity logic are absent.

## Structure
- Shared package `uart_pkg`:
  - receiver state enum (IDLE, START, DATA, PARITY, STOP);
  - `baud_div(clk_hz, baud)` constant function;
  - data width constant 8.
- Sub-module `uart_rx_sync_fifo`:
  - DEPTH×8 register array with push, pop, flush, full, empty and count;
  - reused by the transmit side.

## Test plan
- Send frame 0x55 at the defaults (BAUD_DIV=434) → after stop: `rx_valid`=1, `rx_data`=0x55, `fifo_count`=1.
- Send 0xA3, 0x0F back-to-back, then pulse `ctrl[0]` once → `rx_data`=0x0F, `fifo_count`=1. A second pulse → `rx_valid`=0.
- Send 17 frames with no pops → `fifo_count`=16, `overrun`=1, head = first byte. Raise `ctrl[1]` for one cycle → count 0, `overrun`=0.
- Frame 0x3C with stop bit forced low → `framing_err`=1, `fifo_count` unchanged. A 100-cycle low glitch on `rxd` → no push, FSM back in IDLE.
- FIFO full, with a stop-bit acceptance coinciding with a pop edge → count stays 16 and `overrun` stays 0.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → accepted. 0x07 with parity bit 0 → dropped, `framing_err`=1.
